// File: rtl/tdc_run_ctrl_if.sv
// Result stream from the TDC run controller to its consumer.
// The FIFO head is presented first-word-fall-through with a valid/ready handshake.
interface tdc_run_ctrl_if #(
  parameter int unsigned OUT_W = 32
) ();
  logic [OUT_W-1:0] oData;
  logic             oValid;
  logic             iReady;

  modport master (
    output oData,
    output oValid,
    input  iReady
  );

  modport slave (
    input  oData,
    input  oValid,
    output iReady
  );
endinterface

// File: rtl/tdc_run_ctrl.sv
// Measurement sequencer for the TDC core: arms the core, gates hits, times out stuck
// measurements and buffers completed timestamps in a FIFO for the downstream stream.
module tdc_run_ctrl #(
  parameter int unsigned OUT_W       = 32,
  parameter int unsigned FIFO_AW     = 4,
  parameter int unsigned ARM_CYC     = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStartRun,
  input  logic              iStopRun,
  input  logic [15:0]       iNumMeas,
  input  logic              iHitIn,
  output logic              oHit,
  output logic              oTdcRst,
  input  logic              iTdcDone,
  input  logic [OUT_W-1:0]  iTdcData,
  tdc_run_ctrl_if.master    stream,
  output logic              oBusy,
  output logic              oRunDone,
  output logic [15:0]       oMeasCnt,
  output logic [15:0]       oTimeoutCnt,
  output logic              oOverflow
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned ArmW  = $clog2(ARM_CYC);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [ArmW-1:0] ArmLoad = ArmW'(ARM_CYC - 1);
  localparam logic [TmoW-1:0] TmoLoad = TmoW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StArm, StWait} state_e;

  state_e            state_q, state_d;
  logic [ArmW-1:0]   arm_cnt_q, arm_cnt_d;
  logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [15:0]       num_meas_q, num_meas_d;
  logic [15:0]       meas_cnt_q, meas_cnt_d;
  logic [15:0]       timeout_cnt_q, timeout_cnt_d;
  logic              overflow_q, overflow_d;
  logic              run_done_q, run_done_d;
  logic              tdc_rst_q, tdc_rst_d;
  logic              busy_q, busy_d;
  logic              hit_en_q, hit_en_d;

  logic [FIFO_AW:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]  rd_ptr_q, rd_ptr_d;
  logic [OUT_W-1:0]  mem_q [Depth];

  logic              fifo_empty, fifo_full;
  logic              pop, push, wr_en;
  logic              meas_end;
  logic [15:0]       meas_inc;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q == {~rd_ptr_q[FIFO_AW], rd_ptr_q[FIFO_AW-1:0]});
  assign pop        = ~fifo_empty & stream.iReady;
  assign wr_en      = push & (~fifo_full | pop);
  assign meas_inc   = meas_cnt_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    arm_cnt_d     = arm_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    num_meas_d    = num_meas_q;
    meas_cnt_d    = meas_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    overflow_d    = overflow_q;
    push          = 1'b0;
    meas_end      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (iStartRun && !iStopRun) begin
          num_meas_d = iNumMeas;
          meas_cnt_d = '0;
          overflow_d = 1'b0;
          arm_cnt_d  = ArmLoad;
          state_d    = StArm;
        end
      end
      StArm: begin
        if (iStopRun) begin
          state_d = StIdle;
        end else if (arm_cnt_q == '0) begin
          tmo_cnt_d = TmoLoad;
          state_d   = StWait;
        end else begin
          arm_cnt_d = arm_cnt_q - ArmW'(1);
        end
      end
      StWait: begin
        meas_end = iTdcDone || (tmo_cnt_q == '0);
        // A done arriving on the expiry cycle wins over the timeout.
        if (iTdcDone) begin
          push = 1'b1;
          if (fifo_full && !pop) begin
            overflow_d = 1'b1;
          end
        end else if (tmo_cnt_q == '0) begin
          if (timeout_cnt_q != 16'hFFFF) begin
            timeout_cnt_d = timeout_cnt_q + 16'd1;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q - TmoW'(1);
        end

        if (meas_end) begin
          meas_cnt_d = meas_inc;
          if (iStopRun || ((num_meas_q != '0) && (meas_inc == num_meas_q))) begin
            state_d = StIdle;
          end else begin
            arm_cnt_d = ArmLoad;
            state_d   = StArm;
          end
        end else if (iStopRun) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    run_done_d = (state_q != StIdle) && (state_d == StIdle);
    tdc_rst_d  = (state_d != StWait);
    busy_d     = (state_d != StIdle);
    hit_en_d   = (state_d == StWait);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + (FIFO_AW + 1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (FIFO_AW + 1)'(1);
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q       <= StIdle;
      arm_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      num_meas_q    <= '0;
      meas_cnt_q    <= '0;
      timeout_cnt_q <= '0;
      overflow_q    <= 1'b0;
      run_done_q    <= 1'b0;
      tdc_rst_q     <= 1'b1;
      busy_q        <= 1'b0;
      hit_en_q      <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      arm_cnt_q     <= arm_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      num_meas_q    <= num_meas_d;
      meas_cnt_q    <= meas_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      overflow_q    <= overflow_d;
      run_done_q    <= run_done_d;
      tdc_rst_q     <= tdc_rst_d;
      busy_q        <= busy_d;
      hit_en_q      <= hit_en_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge iClk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= iTdcData;
    end
  end

  assign stream.oValid = ~fifo_empty;
  assign stream.oData  = fifo_empty ? '0 : mem_q[rd_ptr_q[FIFO_AW-1:0]];

  assign oHit        = iHitIn & hit_en_q;
  assign oTdcRst     = tdc_rst_q;
  assign oBusy       = busy_q;
  assign oRunDone    = run_done_q;
  assign oMeasCnt    = meas_cnt_q;
  assign oTimeoutCnt = timeout_cnt_q;
  assign oOverflow   = overflow_q;

endmodule

// File: tb/tb_tdc_run_ctrl.sv
// Directed bench for tdc_run_ctrl with a small FIFO and short arm/timeout windows.
module tb_tdc_run_ctrl;

  logic        clk;
  logic        rst;
  logic        start_run;
  logic        stop_run;
  logic [15:0] num_meas;
  logic        hit_in;
  logic        hit;
  logic        tdc_rst;
  logic        tdc_done;
  logic [31:0] tdc_data;
  logic        busy;
  logic        run_done;
  logic [15:0] meas_cnt;
  logic [15:0] timeout_cnt;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  tdc_run_ctrl_if #(.OUT_W(32)) sif ();

  tdc_run_ctrl #(
    .OUT_W       (32),
    .FIFO_AW     (2),
    .ARM_CYC     (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .iClk        (clk),
    .iRst        (rst),
    .iStartRun   (start_run),
    .iStopRun    (stop_run),
    .iNumMeas    (num_meas),
    .iHitIn      (hit_in),
    .oHit        (hit),
    .oTdcRst     (tdc_rst),
    .iTdcDone    (tdc_done),
    .iTdcData    (tdc_data),
    .stream      (sif),
    .oBusy       (busy),
    .oRunDone    (run_done),
    .oMeasCnt    (meas_cnt),
    .oTimeoutCnt (timeout_cnt),
    .oOverflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst        = 1'b1;
    start_run  = 1'b0;
    stop_run   = 1'b0;
    num_meas   = 16'd0;
    hit_in     = 1'b1;
    tdc_done   = 1'b0;
    tdc_data   = 32'd0;
    sif.iReady = 1'b0;

    #2;
    chk("rst_tdc_rst", tdc_rst, 1);
    chk("rst_hit", hit, 0);
    chk("rst_valid", sif.oValid, 0);
    chk("rst_data", sif.oData, 0);
    chk("rst_busy", busy, 0);
    chk("rst_run_done", run_done, 0);
    chk("rst_meas_cnt", meas_cnt, 0);
    chk("rst_timeout_cnt", timeout_cnt, 0);
    chk("rst_overflow", overflow, 0);
    #10 rst = 1'b0;
    tick(1);

    // Three measurements, each completing on its first WAIT cycle.
    start_run = 1'b1;
    num_meas  = 16'd3;
    tick(1);
    start_run = 1'b0;
    chk("t1_arm_busy", busy, 1);
    chk("t1_arm_tdc_rst", tdc_rst, 1);
    chk("t1_arm_hit_gated", hit, 0);
    tick(3);
    chk("t1_arm_last", tdc_rst, 1);
    tick(1);
    chk("t1_wait_entry", tdc_rst, 0);
    chk("t1_wait_hit", hit, 1);
    tdc_done = 1'b1;
    tdc_data = 32'h11;
    tick(1);
    tdc_done = 1'b0;
    chk("t1_valid_after_push", sif.oValid, 1);
    chk("t1_head_11", sif.oData, 32'h11);
    chk("t1_meas1", meas_cnt, 1);
    chk("t1_rearm", tdc_rst, 1);
    tick(4);
    chk("t1_wait2", tdc_rst, 0);
    tdc_done = 1'b1;
    tdc_data = 32'h22;
    tick(1);
    tdc_done = 1'b0;
    chk("t1_meas2", meas_cnt, 2);
    tick(4);
    tdc_done = 1'b1;
    tdc_data = 32'h33;
    tick(1);
    tdc_done = 1'b0;
    chk("t1_run_done", run_done, 1);
    chk("t1_idle_busy", busy, 0);
    chk("t1_meas3", meas_cnt, 3);
    chk("t1_idle_tdc_rst", tdc_rst, 1);
    tick(1);
    chk("t1_run_done_pulse", run_done, 0);
    hit_in     = 1'b0;
    sif.iReady = 1'b1;
    chk("t1_drain0", sif.oData, 32'h11);
    tick(1);
    chk("t1_drain1", sif.oData, 32'h22);
    tick(1);
    chk("t1_drain2", sif.oData, 32'h33);
    tick(1);
    chk("t1_drained", sif.oValid, 0);
    sif.iReady = 1'b0;

    // Two measurements that both time out.
    start_run = 1'b1;
    num_meas  = 16'd2;
    tick(1);
    start_run = 1'b0;
    tick(4);
    chk("t2_wait1", tdc_rst, 0);
    tick(7);
    chk("t2_wait8_still", tdc_rst, 0);
    chk("t2_no_tmo_yet", timeout_cnt, 0);
    tick(1);
    chk("t2_abort1_arm", tdc_rst, 1);
    chk("t2_tmo1", timeout_cnt, 1);
    chk("t2_meas1", meas_cnt, 1);
    tick(4);
    chk("t2_wait_again", tdc_rst, 0);
    tick(7);
    chk("t2_wait8_again", tdc_rst, 0);
    tick(1);
    chk("t2_run_done", run_done, 1);
    chk("t2_tmo2", timeout_cnt, 2);
    chk("t2_meas2", meas_cnt, 2);
    chk("t2_valid", sif.oValid, 0);

    // Six dones into a four-entry FIFO with the consumer stalled.
    start_run = 1'b1;
    num_meas  = 16'd6;
    tick(1);
    start_run = 1'b0;
    tick(4);
    for (int i = 0; i < 6; i++) begin
      tdc_done = 1'b1;
      tdc_data = 32'hA0 + 32'(i);
      tick(1);
      tdc_done = 1'b0;
      if (i == 3) chk("t3_full_no_ovf", overflow, 0);
      if (i == 4) chk("t3_ovf_5th", overflow, 1);
      if (i < 5) tick(4);
    end
    chk("t3_run_done", run_done, 1);
    chk("t3_meas6", meas_cnt, 6);
    sif.iReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain", sif.oData, 32'hA0 + 32'(i));
      tick(1);
    end
    chk("t3_drained", sif.oValid, 0);
    chk("t3_ovf_sticky", overflow, 1);
    sif.iReady = 1'b0;

    // Done on the same cycle the timeout expires.
    start_run = 1'b1;
    num_meas  = 16'd1;
    tick(1);
    start_run = 1'b0;
    chk("t4_ovf_cleared", overflow, 0);
    tick(4);
    tick(7);
    chk("t4_wait8", tdc_rst, 0);
    tdc_done = 1'b1;
    tdc_data = 32'h5A;
    tick(1);
    tdc_done = 1'b0;
    chk("t4_run_done", run_done, 1);
    chk("t4_tmo_unchanged", timeout_cnt, 2);
    chk("t4_pushed", sif.oData, 32'h5A);
    sif.iReady = 1'b1;
    tick(1);
    sif.iReady = 1'b0;
    chk("t4_drained", sif.oValid, 0);

    // Done while idle must not be captured.
    tdc_done = 1'b1;
    tdc_data = 32'h77;
    tick(1);
    tdc_done = 1'b0;
    chk("idle_done_ignored", sif.oValid, 0);

    // Continuous run stopped mid-WAIT after two measurements.
    start_run = 1'b1;
    num_meas  = 16'd0;
    tick(1);
    start_run = 1'b0;
    tick(4);
    tdc_done = 1'b1;
    tdc_data = 32'h66;
    tick(1);
    tdc_done = 1'b0;
    tick(4);
    tdc_done = 1'b1;
    tdc_data = 32'h67;
    tick(1);
    tdc_done = 1'b0;
    tick(4);
    tick(2);
    chk("t5_in_wait", tdc_rst, 0);
    stop_run = 1'b1;
    tick(1);
    stop_run = 1'b0;
    chk("t5_stop_tdc_rst", tdc_rst, 1);
    chk("t5_stop_run_done", run_done, 1);
    chk("t5_stop_meas", meas_cnt, 2);
    chk("t5_stop_busy", busy, 0);

    // Asynchronous reset in WAIT with two entries queued.
    start_run = 1'b1;
    tick(1);
    start_run = 1'b0;
    tick(4);
    chk("t6_wait", tdc_rst, 0);
    chk("t6_queued_head", sif.oData, 32'h66);
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", sif.oValid, 0);
    chk("t6_data", sif.oData, 0);
    chk("t6_tdc_rst", tdc_rst, 1);
    chk("t6_busy", busy, 0);
    chk("t6_meas", meas_cnt, 0);
    chk("t6_tmo", timeout_cnt, 0);
    #10 rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
